// File: rtl/thread_dispatch_scheduler_pkg.sv
// thread_dispatch_scheduler_pkg
//   Shared constants and types for the issue-side thread dispatch logic.
//   NUM_ALUS    : default issue slots per cycle
//   NUM_THREADS : default hardware thread count
//   TID_W       : thread-ID width (2**TID_W > NUM_THREADS so THREAD_IDLE fits)
//   THREAD_IDLE : slot marker for "nothing issued" (first ID past the last thread)
package thread_dispatch_scheduler_pkg;

   localparam int NUM_ALUS    = 3;
   localparam int NUM_THREADS = 4;
   localparam int TID_W       = 3;
   localparam int THREAD_IDLE = NUM_THREADS;

   typedef logic [TID_W-1:0] tid_t;

   // Modulo-n increment without relying on n being a power of two.
   function automatic int wrap_inc(input int t, input int n);
      return (t + 1 >= n) ? 0 : t + 1;
   endfunction

endpackage

// File: rtl/thread_dispatch_scheduler_rr_multi_pick.sv
// rr_multi_pick
//   Combinational round-robin multi-picker. Scans threads starting at rr_ptr
//   (wrapping modulo NUM_THREADS) and places the k-th eligible thread in slot k,
//   up to NUM_ALUS picks. Unfilled slots carry THREAD_IDLE.
// Ports
//   elig      in   NUM_THREADS          thread may be picked this cycle
//   rr_ptr    in   TID_W                first thread to consider
//   picked    out  NUM_THREADS          one-hot-per-thread pick mask
//   slot_tid  out  NUM_ALUS x TID_W     picked thread ID per slot, or THREAD_IDLE
//   last_tid  out  TID_W                last thread picked in scan order (rr_ptr if none)
//   any_pick  out  1                    at least one thread picked
module rr_multi_pick
   import thread_dispatch_scheduler_pkg::*;
#(
   parameter int NUM_THREADS = thread_dispatch_scheduler_pkg::NUM_THREADS,
   parameter int NUM_ALUS    = thread_dispatch_scheduler_pkg::NUM_ALUS,
   parameter int TID_W       = thread_dispatch_scheduler_pkg::TID_W
) (
   input  logic [NUM_THREADS-1:0] elig,
   input  logic [TID_W-1:0]       rr_ptr,
   output logic [NUM_THREADS-1:0] picked,
   output logic [TID_W-1:0]       slot_tid [NUM_ALUS],
   output logic [TID_W-1:0]       last_tid,
   output logic                   any_pick
);

   localparam logic [TID_W-1:0] IDLE_TID = TID_W'(NUM_THREADS);

   int idx;
   int cnt;

   always_comb begin
      picked   = '0;
      last_tid = rr_ptr;
      any_pick = 1'b0;
      idx      = 0;
      cnt      = 0;
      for (int s = 0; s < NUM_ALUS; s++) begin
         slot_tid[s] = IDLE_TID;
      end
      for (int i = 0; i < NUM_THREADS; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NUM_THREADS) begin
            idx = idx - NUM_THREADS;
         end
         if (elig[idx] && (cnt < NUM_ALUS)) begin
            picked[idx] = 1'b1;
            for (int s = 0; s < NUM_ALUS; s++) begin
               if (s == cnt) begin
                  slot_tid[s] = TID_W'(idx);
               end
            end
            last_tid = TID_W'(idx);
            any_pick = 1'b1;
            cnt      = cnt + 1;
         end
      end
   end

endmodule

// File: rtl/thread_dispatch_scheduler.sv
// thread_dispatch_scheduler
//   Picks up to NUM_ALUS distinct ready threads per cycle in round-robin order,
//   grants them, and registers their IDs into per-ALU issue slots. A slot whose
//   ID equals THREAD_IDLE (= NUM_THREADS) carries no instruction.
//   Optional performance counters are built when DISPATCH_PERF_CNT_EN is defined;
//   otherwise issue_count and cycle_count are tied to zero.
// Ports
//   clk               in   1                    core clock, rising edge
//   rst               in   1                    synchronous, active-high reset
//   thread_req        in   NUM_THREADS          thread has a decoded instruction ready
//   thread_halt       in   NUM_THREADS          pulse: thread finished (sticky until rst)
//   issue_stall       in   1                    downstream cannot accept issue
//   thread_grant      out  NUM_THREADS          combinational grant, consumed at this edge
//   dispatch_threads  out  NUM_ALUS x TID_W     registered slot thread IDs
//   all_halted        out  1                    registered; every thread halted
//   issue_count       out  32                   saturating count of issued slots
//   cycle_count       out  32                   saturating count of non-halted cycles
module thread_dispatch_scheduler
   import thread_dispatch_scheduler_pkg::*;
#(
   parameter int NUM_THREADS = thread_dispatch_scheduler_pkg::NUM_THREADS,
   parameter int NUM_ALUS    = thread_dispatch_scheduler_pkg::NUM_ALUS,
   parameter int TID_W       = thread_dispatch_scheduler_pkg::TID_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_THREADS-1:0] thread_req,
   input  logic [NUM_THREADS-1:0] thread_halt,
   input  logic                   issue_stall,
   output logic [NUM_THREADS-1:0] thread_grant,
   output logic [TID_W-1:0]       dispatch_threads [NUM_ALUS],
   output logic                   all_halted,
   output logic [31:0]            issue_count,
   output logic [31:0]            cycle_count
);

   localparam logic [TID_W-1:0] IDLE_TID = TID_W'(NUM_THREADS);

   logic [NUM_THREADS-1:0] halted;
   logic [TID_W-1:0]       rr_ptr;
   logic [NUM_THREADS-1:0] elig;
   logic [NUM_THREADS-1:0] picked;
   logic [TID_W-1:0]       slot_tid [NUM_ALUS];
   logic [TID_W-1:0]       last_tid;
   logic                   any_pick;
   logic [TID_W-1:0]       rr_next;

   // A thread halting this cycle is already excluded from selection.
   assign elig         = thread_req & ~halted & ~thread_halt;
   assign thread_grant = picked & {NUM_THREADS{~issue_stall & ~rst}};
   assign rr_next      = TID_W'(wrap_inc(int'(last_tid), NUM_THREADS));

   rr_multi_pick #(
      .NUM_THREADS (NUM_THREADS),
      .NUM_ALUS    (NUM_ALUS),
      .TID_W       (TID_W)
   ) u_pick (
      .elig     (elig),
      .rr_ptr   (rr_ptr),
      .picked   (picked),
      .slot_tid (slot_tid),
      .last_tid (last_tid),
      .any_pick (any_pick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         halted     <= '0;
         rr_ptr     <= '0;
         all_halted <= 1'b0;
         for (int s = 0; s < NUM_ALUS; s++) begin
            dispatch_threads[s] <= IDLE_TID;
         end
      end else begin
         halted     <= halted | thread_halt;
         all_halted <= &(halted | thread_halt);
         // Stall freezes both the slots and the pointer so nothing is lost or repeated.
         if (!issue_stall) begin
            for (int s = 0; s < NUM_ALUS; s++) begin
               dispatch_threads[s] <= slot_tid[s];
            end
            if (any_pick) begin
               rr_ptr <= rr_next;
            end
         end
      end
   end

`ifdef DISPATCH_PERF_CNT_EN
   logic [31:0] issue_add;
   logic [32:0] issue_sum;

   // Counts the slots being loaded at this edge, i.e. the instructions issued now.
   always_comb begin
      issue_add = '0;
      for (int s = 0; s < NUM_ALUS; s++) begin
         if (slot_tid[s] < IDLE_TID) begin
            issue_add = issue_add + 32'd1;
         end
      end
   end

   assign issue_sum = {1'b0, issue_count} + {1'b0, issue_add};

   always_ff @(posedge clk) begin
      if (rst) begin
         issue_count <= '0;
         cycle_count <= '0;
      end else begin
         if (!issue_stall) begin
            issue_count <= issue_sum[32] ? 32'hFFFF_FFFF : issue_sum[31:0];
         end
         if (!all_halted && (cycle_count != 32'hFFFF_FFFF)) begin
            cycle_count <= cycle_count + 32'd1;
         end
      end
   end
`else
   assign issue_count = 32'd0;
   assign cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_thread_dispatch_scheduler.sv
module tb_thread_dispatch_scheduler;

   localparam int NT = 4;
   localparam int NA = 3;
   localparam int TW = 3;
   localparam int I  = 4;

`ifdef DISPATCH_PERF_CNT_EN
   localparam logic [31:0] PERF_MASK = 32'hFFFF_FFFF;
`else
   localparam logic [31:0] PERF_MASK = 32'h0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [NT-1:0] thread_req;
   logic [NT-1:0] thread_halt;
   logic          issue_stall;
   logic [NT-1:0] thread_grant;
   logic [TW-1:0] dispatch_threads [NA];
   logic          all_halted;
   logic [31:0]   issue_count;
   logic [31:0]   cycle_count;

   int n_checks = 0;
   int n_pass   = 0;
   int exp_cyc  = 0;
   int exp_iss  = 0;
   bit ah_exp   = 1'b0;
   int gcnt [NT];

   always #5 clk = ~clk;

   thread_dispatch_scheduler dut (
      .clk              (clk),
      .rst              (rst),
      .thread_req       (thread_req),
      .thread_halt      (thread_halt),
      .issue_stall      (issue_stall),
      .thread_grant     (thread_grant),
      .dispatch_threads (dispatch_threads),
      .all_halted       (all_halted),
      .issue_count      (issue_count),
      .cycle_count      (cycle_count)
   );

   function automatic logic [31:0] perf(input int v);
      return 32'(v) & PERF_MASK;
   endfunction

   function automatic logic [31:0] slots(input int a, input int b, input int c);
      return {23'd0, TW'(c), TW'(b), TW'(a)};
   endfunction

   function automatic logic [31:0] slots_now();
      return {23'd0, dispatch_threads[2], dispatch_threads[1], dispatch_threads[0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst && !ah_exp) exp_cyc++;
      #1;
   endtask

   task automatic cyc(input logic [NT-1:0] req, input logic [NT-1:0] halt,
                      input logic stall, input logic [NT-1:0] exp_g, input string tag);
      thread_req  = req;
      thread_halt = halt;
      issue_stall = stall;
      #1;
      check(tag, 32'(thread_grant), 32'(exp_g));
      if (!stall && !rst) exp_iss += $countones(exp_g);
      tick();
   endtask

   initial begin
      rst         = 1'b1;
      thread_req  = '0;
      thread_halt = '0;
      issue_stall = 1'b0;

      // reset
      cyc(4'b1111, 4'b0000, 1'b0, 4'b0000, "rst_grant0");
      cyc(4'b1111, 4'b0000, 1'b0, 4'b0000, "rst_grant1");
      check("rst_slots", slots_now(), slots(I, I, I));
      check("rst_all_halted", 32'(all_halted), 32'd0);
      check("rst_issue_cnt", issue_count, 32'd0);
      check("rst_cycle_cnt", cycle_count, 32'd0);
      rst = 1'b0;

      // full load
      cyc(4'b1111, 4'b0000, 1'b0, 4'b0111, "full_grant0");
      check("full_slots0", slots_now(), slots(0, 1, 2));
      cyc(4'b1111, 4'b0000, 1'b0, 4'b1011, "full_grant1");
      check("full_slots1", slots_now(), slots(3, 0, 1));

      // sparse and wrap (move rr_ptr to 3 first)
      cyc(4'b0100, 4'b0000, 1'b0, 4'b0100, "to_rr3_grant");
      check("to_rr3_slots", slots_now(), slots(2, I, I));
      cyc(4'b0101, 4'b0000, 1'b0, 4'b0101, "sparse_grant");
      check("sparse_slots", slots_now(), slots(0, 2, I));
      cyc(4'b1000, 4'b0000, 1'b0, 4'b1000, "wrap_grant");
      check("wrap_slots", slots_now(), slots(3, I, I));
      cyc(4'b1111, 4'b0000, 1'b0, 4'b0111, "wrap_rr0_grant");
      check("wrap_rr0_slots", slots_now(), slots(0, 1, 2));

      // stall
      for (int k = 0; k < 3; k++) begin
         cyc(4'b1111, 4'b0000, 1'b1, 4'b0000, "stall_grant");
         check("stall_slots", slots_now(), slots(0, 1, 2));
         check("stall_issue_cnt", issue_count, perf(13));
      end
      check("stall_cycle_cnt", cycle_count, perf(exp_cyc));
      cyc(4'b1111, 4'b0000, 1'b0, 4'b1011, "unstall_grant");
      check("unstall_slots", slots_now(), slots(3, 0, 1));

      // halt thread 1
      cyc(4'b1111, 4'b0010, 1'b0, 4'b1101, "halt1_grant");
      check("halt1_slots", slots_now(), slots(2, 3, 0));
      for (int k = 0; k < 4; k++) begin
         cyc(4'b1111, 4'b0000, 1'b0, 4'b1101, "halted1_grant");
         check("halted1_slots", slots_now(), slots(2, 3, 0));
      end
      cyc(4'b1111, 4'b0001, 1'b0, 4'b1100, "halt0_grant");
      check("halt0_slots", slots_now(), slots(2, 3, I));
      cyc(4'b1111, 4'b0100, 1'b0, 4'b1000, "halt2_grant");
      check("halt2_all_halted", 32'(all_halted), 32'd0);
      cyc(4'b1111, 4'b1000, 1'b0, 4'b0000, "halt3_grant");
      ah_exp = 1'b1;
      check("halt3_all_halted", 32'(all_halted), 32'd1);
      check("halt3_slots", slots_now(), slots(I, I, I));
      check("halt3_cycle_cnt", cycle_count, perf(exp_cyc));
      for (int k = 0; k < 3; k++) begin
         cyc(4'b1111, 4'b0000, 1'b0, 4'b0000, "allh_grant");
      end
      check("frozen_cycle_cnt", cycle_count, perf(exp_cyc));
      check("frozen_issue_cnt", issue_count, perf(exp_iss));

      // fairness
      rst = 1'b1;
      cyc(4'b1111, 4'b0000, 1'b0, 4'b0000, "rst2_grant");
      rst     = 1'b0;
      ah_exp  = 1'b0;
      exp_cyc = 0;
      exp_iss = 0;
      check("rst2_all_halted", 32'(all_halted), 32'd0);
      for (int t = 0; t < NT; t++) gcnt[t] = 0;
      thread_req  = 4'b1111;
      thread_halt = 4'b0000;
      issue_stall = 1'b0;
      for (int k = 0; k < 400; k++) begin
         #1;
         for (int t = 0; t < NT; t++) if (thread_grant[t]) gcnt[t]++;
         exp_iss += 3;
         tick();
      end
      for (int t = 0; t < NT; t++) check($sformatf("fair_t%0d", t), 32'(gcnt[t]), 32'd300);
      check("fair_issue_cnt", issue_count, perf(1200));
      check("fair_cycle_cnt", cycle_count, perf(400));

      // reset mid-operation overrides stall and discards slots
      check("pre_rst_slots_busy", 32'(slots_now() != slots(I, I, I)), 32'd1);
      rst = 1'b1;
      cyc(4'b1111, 4'b0000, 1'b1, 4'b0000, "rst_mid_grant");
      check("rst_mid_slots", slots_now(), slots(I, I, I));
      check("rst_mid_issue_cnt", issue_count, 32'd0);
      check("rst_mid_cycle_cnt", cycle_count, 32'd0);
      rst = 1'b0;
      cyc(4'b1111, 4'b0000, 1'b0, 4'b0111, "post_rst_grant");
      check("post_rst_slots", slots_now(), slots(0, 1, 2));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
